// File: rtl/step_window_tracker.sv
// step_window_tracker: per-window step statistics for the step-counter display.
// A rising edge of clk2sec closes the current window. The window count, the
// saturating total, the early-window over-rate count and the accumulated
// high-activity seconds then update, and win_valid pulses for one cycle.
`timescale 1ns/1ps

module step_window_tracker #(
  parameter int STEP_MAX         = 9999,
  parameter int RATE_THRESH      = 32,
  parameter int FIRST_WINDOWS    = 5,
  parameter int HIGH_RATE        = 64,
  parameter int HIGH_MIN_WINDOWS = 30
) (
  input  logic        clk100MHz,
  input  logic        reset_n,
  input  logic        clk2sec,
  input  logic        step_in,
  output logic [13:0] total_steps,
  output logic [15:0] win_steps,
  output logic [3:0]  over_cnt,
  output logic [15:0] high_secs,
  output logic        win_valid
);

  // Thresholds are per-second rates, so they are doubled for a 2 s window.
  localparam logic [16:0] RATE_LIM = 17'(2 * RATE_THRESH);
  localparam logic [16:0] HIGH_LIM = 17'(2 * HIGH_RATE);
  localparam logic [16:0] RUN_ADD  = 17'(2 * HIGH_MIN_WINDOWS);
  localparam logic [13:0] STEP_CAP = 14'(STEP_MAX);
  localparam int          WIDX_W   = $clog2(FIRST_WINDOWS + 1);
  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(FIRST_WINDOWS);
  localparam int          RUN_W    = $clog2(HIGH_MIN_WINDOWS + 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(HIGH_MIN_WINDOWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ACTIVE} hstate_e;

  hstate_e           state_q, state_d;
  logic              tick_q, step_q;
  logic [15:0]       cur_cnt_q, cur_cnt_d;
  logic [13:0]       total_steps_q, total_steps_d;
  logic [15:0]       win_steps_q, win_steps_d;
  logic [3:0]        over_cnt_q, over_cnt_d;
  logic [15:0]       high_secs_q, high_secs_d;
  logic              win_valid_q, win_valid_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;

  logic win_end, step_edge, win_high, win_over;

  assign win_end   = clk2sec & ~tick_q;
  assign step_edge = step_in & ~step_q;
  assign win_high  = {1'b0, cur_cnt_q} > HIGH_LIM;
  assign win_over  = {1'b0, cur_cnt_q} > RATE_LIM;

  // Adds to the high-activity seconds, pinning at all-ones on overflow.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [16:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + b;
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // All state registers: edge detectors, counters, window outputs and the FSM.
  always_ff @(posedge clk100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      tick_q        <= 1'b0;
      step_q        <= 1'b0;
      cur_cnt_q     <= '0;
      total_steps_q <= '0;
      win_steps_q   <= '0;
      over_cnt_q    <= '0;
      high_secs_q   <= '0;
      win_valid_q   <= 1'b0;
      widx_q        <= '0;
      run_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      tick_q        <= clk2sec;
      step_q        <= step_in;
      cur_cnt_q     <= cur_cnt_d;
      total_steps_q <= total_steps_d;
      win_steps_q   <= win_steps_d;
      over_cnt_q    <= over_cnt_d;
      high_secs_q   <= high_secs_d;
      win_valid_q   <= win_valid_d;
      widx_q        <= widx_d;
      run_cnt_q     <= run_cnt_d;
    end
  end

  // Step counting and window close; a step landing on the closing edge opens the next window.
  always_comb begin
    cur_cnt_d     = cur_cnt_q;
    total_steps_d = total_steps_q;
    win_steps_d   = win_steps_q;
    over_cnt_d    = over_cnt_q;
    widx_d        = widx_q;
    win_valid_d   = win_end;
    if (step_edge && total_steps_q < STEP_CAP) total_steps_d = total_steps_q + 14'd1;
    if (win_end) begin
      cur_cnt_d   = step_edge ? 16'd1 : 16'd0;
      win_steps_d = cur_cnt_q;
      if (widx_q < WIDX_LAST) begin
        widx_d = widx_q + WIDX_W'(1);
        if (win_over) over_cnt_d = over_cnt_q + 4'd1;
      end
    end else if (step_edge && cur_cnt_q != 16'hFFFF) begin
      cur_cnt_d = cur_cnt_q + 16'd1;
    end
  end

  // High-activity next state, advanced only when a window closes.
  always_comb begin
    state_d = state_q;
    if (win_end) begin
      case (state_q)
        S_IDLE:   if (win_high) state_d = (HIGH_MIN_WINDOWS == 1) ? S_ACTIVE : S_RUN;
        S_RUN:    if (!win_high) state_d = S_IDLE;
                  else if (run_cnt_q == RUN_LAST) state_d = S_ACTIVE;
        S_ACTIVE: if (!win_high) state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // High-activity run length and accumulated seconds for the current state.
  always_comb begin
    run_cnt_d   = run_cnt_q;
    high_secs_d = high_secs_q;
    if (win_end) begin
      case (state_q)
        S_IDLE: begin
          if (win_high) begin
            run_cnt_d = RUN_W'(1);
            if (HIGH_MIN_WINDOWS == 1) high_secs_d = sat_add(high_secs_q, RUN_ADD);
          end
        end
        S_RUN: begin
          if (!win_high) run_cnt_d = '0;
          else if (run_cnt_q == RUN_LAST) high_secs_d = sat_add(high_secs_q, RUN_ADD);
          else run_cnt_d = run_cnt_q + RUN_W'(1);
        end
        S_ACTIVE: begin
          if (!win_high) run_cnt_d = '0;
          else high_secs_d = sat_add(high_secs_q, 17'd2);
        end
        default: run_cnt_d = '0;
      endcase
    end
  end

  assign total_steps = total_steps_q;
  assign win_steps   = win_steps_q;
  assign over_cnt    = over_cnt_q;
  assign high_secs   = high_secs_q;
  assign win_valid   = win_valid_q;

endmodule

// File: tb/tb_step_window_tracker.sv
// Directed bench for step_window_tracker, built with HIGH_MIN_WINDOWS=3.
`timescale 1ns/1ps

module tb_step_window_tracker;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk2sec = 1'b0;
  logic        step_in = 1'b0;
  logic [13:0] total_steps;
  logic [15:0] win_steps;
  logic [3:0]  over_cnt;
  logic [15:0] high_secs;
  logic        win_valid;

  int checks = 0;
  int passes = 0;

  step_window_tracker #(
    .STEP_MAX(9999), .RATE_THRESH(32), .FIRST_WINDOWS(5),
    .HIGH_RATE(64), .HIGH_MIN_WINDOWS(3)
  ) dut (
    .clk100MHz(clk), .reset_n(reset_n), .clk2sec(clk2sec), .step_in(step_in),
    .total_steps(total_steps), .win_steps(win_steps), .over_cnt(over_cnt),
    .high_secs(high_secs), .win_valid(win_valid)
  );

  always #5 clk = ~clk;

  task automatic do_reset;
    @(negedge clk);
    reset_n = 1'b0; step_in = 1'b0; clk2sec = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic do_steps(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); step_in = 1'b1;
      @(negedge clk); step_in = 1'b0;
    end
  endtask

  // Returns on the negedge after the closing posedge, while win_valid is high.
  task automatic do_tick;
    @(negedge clk); clk2sec = 1'b1;
    @(negedge clk); clk2sec = 1'b0;
  endtask

  task automatic test_reset;
    int pulses;
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); step_in = ~step_in; clk2sec = ~clk2sec;
    end
    @(negedge clk);
    checks++; if (total_steps !== 14'd0) $display("[TB] FAIL reset_total: got %0d want 0", total_steps); else passes++;
    checks++; if ({win_steps, over_cnt, high_secs, win_valid} !== 37'd0)
      $display("[TB] FAIL reset_outputs: got ws=%0d oc=%0d hs=%0d v=%0b want all 0", win_steps, over_cnt, high_secs, win_valid);
    else passes++;
    step_in = 1'b0; clk2sec = 1'b0; reset_n = 1'b1;
    repeat (5) @(negedge clk);
    do_tick();
    checks++; if (win_steps !== 16'd0) $display("[TB] FAIL reset_first_win: got %0d want 0", win_steps); else passes++;
    pulses = win_valid ? 1 : 0;
    repeat (6) begin @(negedge clk); if (win_valid) pulses++; end
    checks++; if (pulses !== 1) $display("[TB] FAIL reset_valid_pulses: got %0d want 1", pulses); else passes++;
    do_steps(3);
    checks++; if (total_steps !== 14'd3) $display("[TB] FAIL pre_async_total: got %0d want 3", total_steps); else passes++;
    @(posedge clk); #2 reset_n = 1'b0; #1;
    checks++; if (total_steps !== 14'd0) $display("[TB] FAIL async_reset_total: got %0d want 0", total_steps); else passes++;
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_basic;
    do_reset();
    do_steps(70); do_tick();
    checks++; if (win_steps !== 16'd70) $display("[TB] FAIL basic_win1: got %0d want 70", win_steps); else passes++;
    checks++; if (over_cnt !== 4'd1) $display("[TB] FAIL basic_over1: got %0d want 1", over_cnt); else passes++;
    checks++; if (win_valid !== 1'b1) $display("[TB] FAIL basic_valid: got %0b want 1", win_valid); else passes++;
    do_steps(10); do_tick();
    checks++; if (win_steps !== 16'd10) $display("[TB] FAIL basic_win2: got %0d want 10", win_steps); else passes++;
    checks++; if (over_cnt !== 4'd1) $display("[TB] FAIL basic_over2: got %0d want 1", over_cnt); else passes++;
    checks++; if (total_steps !== 14'd80) $display("[TB] FAIL basic_total: got %0d want 80", total_steps); else passes++;
    @(negedge clk);
    checks++; if (win_valid !== 1'b0) $display("[TB] FAIL basic_valid_drop: got %0b want 0", win_valid); else passes++;
  endtask

  task automatic test_simultaneous;
    do_reset();
    do_steps(5);
    @(negedge clk); step_in = 1'b1; clk2sec = 1'b1;
    @(negedge clk); step_in = 1'b0; clk2sec = 1'b0;
    checks++; if (win_steps !== 16'd5) $display("[TB] FAIL simul_win: got %0d want 5", win_steps); else passes++;
    checks++; if (total_steps !== 14'd6) $display("[TB] FAIL simul_total: got %0d want 6", total_steps); else passes++;
    do_tick();
    checks++; if (win_steps !== 16'd1) $display("[TB] FAIL simul_next_win: got %0d want 1", win_steps); else passes++;
    checks++; if (total_steps !== 14'd6) $display("[TB] FAIL simul_next_total: got %0d want 6", total_steps); else passes++;
  endtask

  task automatic test_level_inputs;
    int pulses;
    do_reset();
    @(negedge clk); step_in = 1'b1;
    repeat (20) @(negedge clk);
    step_in = 1'b0;
    checks++; if (total_steps !== 14'd1) $display("[TB] FAIL level_step_total: got %0d want 1", total_steps); else passes++;
    clk2sec = 1'b1; pulses = 0;
    repeat (10) begin @(negedge clk); if (win_valid) pulses++; end
    clk2sec = 1'b0;
    checks++; if (pulses !== 1) $display("[TB] FAIL level_tick_pulses: got %0d want 1", pulses); else passes++;
    checks++; if (win_steps !== 16'd1) $display("[TB] FAIL level_win: got %0d want 1", win_steps); else passes++;
  endtask

  task automatic test_high_activity;
    int wins[6]  = '{130, 130, 130, 130, 10, 130};
    int exp_hs[6] = '{0, 0, 6, 8, 8, 8};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      do_steps(wins[i]); do_tick();
      checks++; if (high_secs !== 16'(exp_hs[i]))
        $display("[TB] FAIL high_secs_w%0d: got %0d want %0d", i, high_secs, exp_hs[i]);
      else passes++;
    end
    checks++; if (over_cnt !== 4'd4) $display("[TB] FAIL high_over: got %0d want 4", over_cnt); else passes++;
  endtask

  task automatic test_thresholds;
    int wins[6]  = '{129, 129, 128, 129, 129, 129};
    int exp_hs[6] = '{0, 0, 0, 0, 0, 6};
    do_reset();
    do_steps(64); do_tick();
    checks++; if (over_cnt !== 4'd0) $display("[TB] FAIL rate_at_limit: got %0d want 0", over_cnt); else passes++;
    do_steps(65); do_tick();
    checks++; if (over_cnt !== 4'd1) $display("[TB] FAIL rate_above_limit: got %0d want 1", over_cnt); else passes++;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      do_steps(wins[i]); do_tick();
      checks++; if (high_secs !== 16'(exp_hs[i]))
        $display("[TB] FAIL high_bound_w%0d: got %0d want %0d", i, high_secs, exp_hs[i]);
      else passes++;
    end
  endtask

  task automatic test_saturation;
    do_reset();
    do_steps(10010);
    checks++; if (total_steps !== 14'd9999) $display("[TB] FAIL total_sat: got %0d want 9999", total_steps); else passes++;
    do_tick();
    checks++; if (win_steps !== 16'd10010) $display("[TB] FAIL sat_win: got %0d want 10010", win_steps); else passes++;
    checks++; if (total_steps !== 14'd9999) $display("[TB] FAIL total_sat_hold: got %0d want 9999", total_steps); else passes++;
  endtask

  task automatic test_early_windows;
    int exp_over[7] = '{1, 2, 3, 4, 5, 5, 5};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      do_steps(100); do_tick();
      checks++; if (over_cnt !== 4'(exp_over[i]))
        $display("[TB] FAIL early_over_w%0d: got %0d want %0d", i, over_cnt, exp_over[i]);
      else passes++;
    end
    checks++; if (high_secs !== 16'd0) $display("[TB] FAIL early_high: got %0d want 0", high_secs); else passes++;
    checks++; if (total_steps !== 14'd700) $display("[TB] FAIL early_total: got %0d want 700", total_steps); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_simultaneous();
    test_level_inputs();
    test_high_activity();
    test_thresholds();
    test_saturation();
    test_early_windows();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
